// File: rtl/main_memory_ctrl.sv
// Main-memory stage behind the cache control FSM.
// A one-cycle MStrobe/MRW request is captured, held for WAIT_CYCLES wait
// states, and then applied to a synchronous backing array. The result is
// reported with a one-cycle MReady pulse. A strobe that arrives while a
// request is in flight is dropped and sets the sticky MErr flag.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | waiting for MStrobe; request latches and counter load here
//   S_WAIT   | wait states; counter steps down, leaves when it reads 1
//   S_ACCESS | array write, or read into the MDataOut register
//   S_DONE   | completion; MReady follows as a registered pulse
module main_memory_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              MBusy,
    output logic              MErr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    // Backing array; contents survive reset.
    logic [DATA_W-1:0]   mem_q [2**ADDR_W];

    // Next-state, request capture, wait countdown and status decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (MStrobe) begin
                    rw_d    = MRW;
                    addr_d  = MAddr;
                    wdata_d = MDataIn;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // <= rather than == so a corrupted zero count cannot wedge the FSM
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes outside IDLE are dropped, never queued.
        if (MStrobe && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end

        // Busy tracks the state register; ready lags DONE by one cycle.
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_q == S_DONE);
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            if ((state_q == S_ACCESS) && !rw_q) begin
                rdata_q <= mem_q[addr_q];
            end
        end
    end

    // Array write; a reset on the ACCESS edge suppresses it.
    always_ff @(posedge clk) begin
        if (reset && (state_q == S_ACCESS) && rw_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign MDataOut = rdata_q;
    assign MReady   = ready_q;
    assign MBusy    = busy_q;
    assign MErr     = err_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl. Instance 0 uses four wait
// states, instance 1 uses none. Expected results are queued when a request
// is driven and retired when MReady is seen.
module tb_main_memory_ctrl;

    logic        clk;
    logic        rst     [2];
    logic        strobe  [2];
    logic        mrw     [2];
    logic [7:0]  maddr   [2];
    logic [31:0] mdin    [2];
    logic [31:0] dout    [2];
    logic        ready   [2];
    logic        busy    [2];
    logic        err     [2];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          rw;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [2][256];

    main_memory_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(4), .CNT_W(8)) u_dut_w4 (
        .clk      (clk),
        .reset    (rst[0]),
        .MStrobe  (strobe[0]),
        .MRW      (mrw[0]),
        .MAddr    (maddr[0]),
        .MDataIn  (mdin[0]),
        .MDataOut (dout[0]),
        .MReady   (ready[0]),
        .MBusy    (busy[0]),
        .MErr     (err[0])
    );

    main_memory_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0), .CNT_W(8)) u_dut_w0 (
        .clk      (clk),
        .reset    (rst[1]),
        .MStrobe  (strobe[1]),
        .MRW      (mrw[1]),
        .MAddr    (maddr[1]),
        .MDataIn  (mdin[1]),
        .MDataOut (dout[1]),
        .MReady   (ready[1]),
        .MBusy    (busy[1]),
        .MErr     (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on instance idx and retire it against the scoreboard.
    // With intrude set, a stray write strobe to 0x02 is fired during WAIT.
    task automatic do_req(input int idx, input bit rw, input logic [7:0] addr,
                          input logic [31:0] data, input int exp_lat, input bit intrude);
        exp_t e;
        int   n;
        bit   got;
        e.rw   = rw;
        e.data = rw ? data : mdl[idx][addr];
        sb.push_back(e);
        if (rw) mdl[idx][addr] = data;

        @(negedge clk);
        strobe[idx] = 1'b1;
        mrw[idx]    = rw;
        maddr[idx]  = addr;
        mdin[idx]   = data;
        @(posedge clk);
        #1;
        chk("busy_rise", 32'(busy[idx]), 32'd1);
        strobe[idx] = 1'b0;
        mrw[idx]    = ~rw;
        maddr[idx]  = 8'($urandom);
        mdin[idx]   = $urandom;

        n   = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (intrude && n == 1) begin
                strobe[idx] = 1'b1;
                mrw[idx]    = 1'b1;
                maddr[idx]  = 8'h02;
                mdin[idx]   = 32'h1111_1111;
            end
            if (intrude && n == 2) strobe[idx] = 1'b0;
            if (intrude && n == 3) chk("err_set", 32'(err[idx]), 32'd1);
            if (ready[idx]) got = 1'b1;
        end

        if (!got) begin
            chk("ready_timeout", 32'd0, 32'd1);
            e = sb.pop_front();
            return;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        e = sb.pop_front();
        if (!e.rw) chk("rdata", dout[idx], e.data);

        @(posedge clk);
        #1;
        chk("ready_pulse", 32'(ready[idx]), 32'd0);
        if (!e.rw) chk("rdata_hold", dout[idx], e.data);
    endtask

    initial begin
        int rdy_seen;
        for (int i = 0; i < 2; i++) begin
            rst[i]    = 1'b0;
            strobe[i] = 1'b0;
            mrw[i]    = 1'b0;
            maddr[i]  = '0;
            mdin[i]   = '0;
        end

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("idle_ready", 32'(ready[0]), 32'd0);
            chk("idle_busy",  32'(busy[0]),  32'd0);
            chk("idle_err",   32'(err[0]),   32'd0);
            chk("idle_dout",  dout[0],       32'd0);
        end
        chk("idle_dout_w0", dout[1], 32'd0);

        // Write then read, four wait states
        do_req(0, 1'b1, 8'h12, 32'hDEAD_BEEF, 6, 1'b0);
        do_req(0, 1'b0, 8'h12, 32'h0,         6, 1'b0);

        // Back-to-back alternating write/read pairs
        for (int a = 0; a < 8; a++) begin
            do_req(0, 1'b1, 8'(a), 32'h0A5A_0000 + 32'($urandom_range(0, 65535)), 6, 1'b0);
            do_req(0, 1'b0, 8'(a), 32'h0, 6, 1'b0);
        end
        chk("b2b_err", 32'(err[0]), 32'd0);

        // Busy violation: stray write must be dropped and flagged
        do_req(0, 1'b0, 8'h01, 32'h0, 6, 1'b1);
        chk("err_sticky", 32'(err[0]), 32'd1);
        do_req(0, 1'b0, 8'h02, 32'h0, 6, 1'b0);
        chk("err_sticky2", 32'(err[0]), 32'd1);

        // Reset during the second wait cycle of a write
        do_req(0, 1'b1, 8'h30, 32'hAAAA_AAAA, 6, 1'b0);
        @(negedge clk);
        strobe[0] = 1'b1;
        mrw[0]    = 1'b1;
        maddr[0]  = 8'h30;
        mdin[0]   = 32'h5555_5555;
        @(posedge clk);
        #1;
        strobe[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy",  32'(busy[0]),  32'd0);
        chk("abort_ready", 32'(ready[0]), 32'd0);
        chk("abort_err",   32'(err[0]),   32'd0);
        @(negedge clk);
        rst[0]   = 1'b1;
        rdy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (ready[0] || busy[0]) rdy_seen++;
        end
        chk("abort_quiet", 32'(rdy_seen), 32'd0);
        do_req(0, 1'b0, 8'h30, 32'h0, 6, 1'b0);

        // Zero wait states
        do_req(1, 1'b1, 8'hFF, 32'h0000_0055, 2, 1'b0);
        do_req(1, 1'b0, 8'hFF, 32'h0,         2, 1'b0);
        chk("w0_err", 32'(err[1]), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
- Main-memory stage directly downstream of the cache control FSM.
- Accepts the one-cycle MStrobe/MRW request the cache issues on a read miss or write-through, and applies a programmable number of wait states.
- Performs the read or write on a synchronous backing array, then returns data and a one-cycle MReady completion pulse.
- Makes the cache-side wait-state counter assumption checkable against a real memory model; flags protocol violations.

Parameters:
- ADDR_W, 8, address width; array depth is 2**ADDR_W words.
- DATA_W, 32, word width.
- WAIT_CYCLES, 4, wait-state cycles between request capture and array access (0 legal).
- CNT_W, 8, wait counter width; requires WAIT_CYCLES < 2**CNT_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- MStrobe  input  1  request pulse from cache control, sampled only in IDLE.
- MRW  input  1  request type: 1 = write, 0 = read; sampled with MStrobe.
- MAddr  input  ADDR_W  word address; sampled with MStrobe.
- MDataIn  input  DATA_W  write data; sampled with MStrobe.
- MDataOut  output  DATA_W  read data register; valid while MReady=1, held until next read completes.
- MReady  output  1  one-cycle completion pulse for reads and writes.
- MBusy  output  1  high in every state except IDLE.
- MErr  output  1  sticky protocol error; cleared only by reset.

Behaviour:
- The design has one clock domain; reset is synchronous and active-low.
- Reset values: state=IDLE, counter=0, MDataOut=0, MReady=0, MBusy=0, MErr=0, request latches=0. Array contents are not reset.
- The FSM has four states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - MStrobe=0: stay in IDLE.
  - MStrobe=1: latch MRW, MAddr and MDataIn, and load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT:
  - Counter decrements by 1 each cycle.
  - When counter==1 at the clock edge, go to ACCESS.
  - Exactly WAIT_CYCLES cycles are spent in WAIT.
- ACCESS (one cycle):
  - Write: array[addr] <= data at the end of the cycle.
  - Read: MDataOut <= array[addr] at the end of the cycle.
  - Always go to DONE.
- DONE (one cycle): MReady=1, then return to IDLE.
- Latency: with the strobe sampled at edge E0, MReady is high in the cycle following edge E0+WAIT_CYCLES+2 (WAIT_CYCLES=4 gives 6 cycles). The next request is accepted no earlier than the cycle after DONE.
- MBusy is a registered decode of state: 1 in WAIT, ACCESS and DONE.
- Request latches are stable from capture until DONE; input changes after capture have no effect.
- MStrobe=1 while in WAIT, ACCESS or DONE: the request is ignored (not queued), MErr is set to 1 on the next edge, and the operation in flight completes unaffected.
- MRW, MAddr and MDataIn are don't-care when MStrobe=0.
- Reset mid-operation:
  - Return to IDLE immediately at the edge.
  - No array write occurs unless the ACCESS edge already passed.
  - MReady is not issued for the aborted request.
- Address wrap: MAddr indexes modulo 2**ADDR_W; no out-of-range case exists.
- Read-after-write to the same address returns the new data (sequential transactions, no hazard).

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, then release with MStrobe=0 -> MReady=0, MBusy=0, MErr=0, MDataOut=0 for 10 cycles.
- Write then read, WAIT_CYCLES=4:
  - Strobe write at addr 0x12 with data 0xDEADBEEF -> MBusy rises the next cycle; MReady pulses exactly once, 6 cycles after the strobe edge.
  - Then strobe a read at 0x12 -> MReady after 6 cycles with MDataOut=0xDEADBEEF, held after MReady drops.
- Zero wait (WAIT_CYCLES=0): write 0x00000055 to 0xFF, then read 0xFF -> each MReady arrives 2 cycles after its strobe; MDataOut=0x00000055.
- Busy violation:
  - Strobe a read at 0x01, then strobe a write at 0x02 with 0x11111111 while MBusy=1 -> MErr=1 and stays 1.
  - First read completes normally; a later read of 0x02 returns its prior contents, not 0x11111111.
- Reset mid-write:
  - Preload 0x30=0xAAAAAAAA.
  - Strobe a write of 0x55555555 to 0x30 and assert reset during the 2nd WAIT cycle -> no MReady, state IDLE.
  - A subsequent read of 0x30 returns 0xAAAAAAAA.
- Back-to-back:
  - Strobe each new request the cycle after MReady, for 8 alternating write/read pairs at addresses 0x00–0x07 -> every read matches its write; MErr=0.
